// File: rtl/crc_stream.sv
// rtl/crc_stream.sv - framed streaming CRC generator/checker with valid/ready on input and result
// Optional macro CRC_STREAM_CHECK_EN adds crc_exp_i/crc_ok_o frame-check compare.
module crc_stream #(
  parameter logic [63:0] POLY       = 64'h8005,
  parameter int          CRC_SIZE   = 16,
  parameter int          DATA_WIDTH = 8,
  parameter logic [63:0] INIT       = 64'h0000,
  parameter string       REF_IN     = "TRUE",
  parameter string       REF_OUT    = "TRUE",
  parameter logic [63:0] XOR_OUT    = 64'hFFFF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    soft_reset_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic [DATA_WIDTH/8-1:0] keep_i,
  input  logic                    last_i,
  output logic [CRC_SIZE-1:0]     crc_o,
  output logic                    crc_valid_o,
`ifdef CRC_STREAM_CHECK_EN
  input  logic                    crc_ready_i,
  input  logic [CRC_SIZE-1:0]     crc_exp_i,
  output logic                    crc_ok_o
`else
  input  logic                    crc_ready_i
`endif
);

  localparam int                  NB        = DATA_WIDTH / 8;
  localparam logic [CRC_SIZE-1:0] L_POLY    = POLY[CRC_SIZE-1:0];
  localparam logic [CRC_SIZE-1:0] L_INIT    = INIT[CRC_SIZE-1:0];
  localparam logic [CRC_SIZE-1:0] L_XOR_OUT = XOR_OUT[CRC_SIZE-1:0];
  localparam bit                  L_REF_IN  = (REF_IN == "TRUE");
  localparam bit                  L_REF_OUT = (REF_OUT == "TRUE");

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CRC_SIZE-1:0] r_crc;
  logic [CRC_SIZE-1:0] r_crc_out;
  logic [CRC_SIZE-1:0] w_crc_step;
  logic [CRC_SIZE-1:0] w_crc_final;
  logic [NB-1:0]       w_byte_en;
  logic                w_ready;
  logic                w_crc_valid;
  logic                w_accept;

  // A byte is only folded in while every lower byte of the beat is also enabled.
  function automatic logic [CRC_SIZE-1:0] f_step(input logic [CRC_SIZE-1:0] crc,
                                                 input logic [DATA_WIDTH-1:0] data,
                                                 input logic [NB-1:0] en);
    logic [CRC_SIZE-1:0] c;
    logic [7:0]          b;
    logic                on;
    logic                fb;
    c  = crc;
    on = 1'b1;
    for (int k = 0; k < NB; k++) begin
      on = on & en[k];
      b  = data[8*k +: 8];
      if (L_REF_IN) begin
        for (int j = 0; j < 8; j++) b[j] = data[8*k + 7 - j];
      end
      if (on) begin
        for (int i = 7; i >= 0; i--) begin
          fb = c[CRC_SIZE-1] ^ b[i];
          c  = {c[CRC_SIZE-2:0], 1'b0} ^ (fb ? L_POLY : '0);
        end
      end
    end
    return c;
  endfunction

  function automatic logic [CRC_SIZE-1:0] f_finish(input logic [CRC_SIZE-1:0] crc);
    logic [CRC_SIZE-1:0] r;
    r = crc;
    if (L_REF_OUT) begin
      for (int i = 0; i < CRC_SIZE; i++) r[i] = crc[CRC_SIZE-1-i];
    end
    return r ^ L_XOR_OUT;
  endfunction

  assign w_byte_en   = last_i ? keep_i : '1;
  assign w_crc_step  = f_step(r_crc, data_i, w_byte_en);
  assign w_crc_final = f_finish(w_crc_step);
  assign w_accept    = valid_i & w_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b1;
    w_crc_valid = 1'b0;
    case (r_state)
      S_IDLE: if (valid_i) w_state_nxt = last_i ? S_HOLD : S_BUSY;
      S_BUSY: if (valid_i && last_i) w_state_nxt = S_HOLD;
      S_HOLD: begin
        w_ready     = 1'b0;
        w_crc_valid = 1'b1;
        if (crc_ready_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_crc     <= L_INIT;
      r_crc_out <= '0;
    end else if (soft_reset_i) begin
      r_state <= S_IDLE;
      r_crc   <= L_INIT;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt == S_IDLE) r_crc <= L_INIT;
      else if (w_accept)         r_crc <= w_crc_step;
      if (w_accept && last_i)    r_crc_out <= w_crc_final;
    end
  end

`ifdef CRC_STREAM_CHECK_EN
  logic r_ok;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                   r_ok <= 1'b0;
    else if (soft_reset_i)       r_ok <= 1'b0;
    else if (w_accept && last_i) r_ok <= (w_crc_final == crc_exp_i);
  end

  assign crc_ok_o = r_ok;
`endif

  assign ready_o     = w_ready;
  assign crc_valid_o = w_crc_valid;
  assign crc_o       = r_crc_out;

endmodule

// File: tb/tb_crc_stream.sv
// tb/tb_crc_stream.sv - directed self-checking bench for crc_stream
// Covers CRC-16/MAXIM, CRC-16/CCITT-FALSE and CRC-32 (32-bit beats) instances.
module tb_crc_stream;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  // Instances 0 (MAXIM) and 1 (CCITT-FALSE) use 8-bit beats.
  logic        v8   [2];
  logic [7:0]  d8   [2];
  logic        k8   [2];
  logic        l8   [2];
  logic        sr8  [2];
  logic        cr8  [2];
  logic        rdy8 [2];
  logic [15:0] crc8 [2];
  logic        cv8  [2];
`ifdef CRC_STREAM_CHECK_EN
  logic [15:0] exp8 [2];
  logic        ok8  [2];
`endif

  logic        v32, l32, sr32, cr32, rdy32, cv32;
  logic [31:0] d32, crc32;
  logic [3:0]  k32;
`ifdef CRC_STREAM_CHECK_EN
  logic [31:0] exp32;
  logic        ok32;
`endif

  logic [7:0] msg [9];

  crc_stream u_maxim (
    .clk_i(clk), .rst_i(rst), .soft_reset_i(sr8[0]), .valid_i(v8[0]), .ready_o(rdy8[0]),
    .data_i(d8[0]), .keep_i(k8[0]), .last_i(l8[0]), .crc_o(crc8[0]), .crc_valid_o(cv8[0]),
`ifdef CRC_STREAM_CHECK_EN
    .crc_ready_i(cr8[0]), .crc_exp_i(exp8[0]), .crc_ok_o(ok8[0])
`else
    .crc_ready_i(cr8[0])
`endif
  );

  crc_stream #(
    .POLY(64'h1021), .CRC_SIZE(16), .DATA_WIDTH(8), .INIT(64'hFFFF),
    .REF_IN("FALSE"), .REF_OUT("FALSE"), .XOR_OUT(64'h0)
  ) u_ccitt (
    .clk_i(clk), .rst_i(rst), .soft_reset_i(sr8[1]), .valid_i(v8[1]), .ready_o(rdy8[1]),
    .data_i(d8[1]), .keep_i(k8[1]), .last_i(l8[1]), .crc_o(crc8[1]), .crc_valid_o(cv8[1]),
`ifdef CRC_STREAM_CHECK_EN
    .crc_ready_i(cr8[1]), .crc_exp_i(exp8[1]), .crc_ok_o(ok8[1])
`else
    .crc_ready_i(cr8[1])
`endif
  );

  crc_stream #(
    .POLY(64'h04C11DB7), .CRC_SIZE(32), .DATA_WIDTH(32), .INIT(64'hFFFFFFFF),
    .REF_IN("TRUE"), .REF_OUT("TRUE"), .XOR_OUT(64'hFFFFFFFF)
  ) u_crc32 (
    .clk_i(clk), .rst_i(rst), .soft_reset_i(sr32), .valid_i(v32), .ready_o(rdy32),
    .data_i(d32), .keep_i(k32), .last_i(l32), .crc_o(crc32), .crc_valid_o(cv32),
`ifdef CRC_STREAM_CHECK_EN
    .crc_ready_i(cr32), .crc_exp_i(exp32), .crc_ok_o(ok32)
`else
    .crc_ready_i(cr32)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send8(input int u, input logic [7:0] b, input logic last);
    v8[u] = 1'b1; d8[u] = b; l8[u] = last; k8[u] = 1'b1;
    tick();
    v8[u] = 1'b0; l8[u] = 1'b0;
  endtask

  task automatic send_msg(input int u, input int gap);
    for (int i = 0; i < 9; i++) begin
      send8(u, msg[i], i == 8);
      if (i < 8) for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic ack8(input int u);
    cr8[u] = 1'b1;
    tick();
    cr8[u] = 1'b0;
  endtask

  task automatic send32(input logic [31:0] d, input logic [3:0] k, input logic last);
    v32 = 1'b1; d32 = d; k32 = k; l32 = last;
    tick();
    v32 = 1'b0; l32 = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    msg   = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    for (int u = 0; u < 2; u++) begin
      v8[u] = 0; d8[u] = 0; k8[u] = 0; l8[u] = 0; sr8[u] = 0; cr8[u] = 0;
`ifdef CRC_STREAM_CHECK_EN
      exp8[u] = 16'h0;
`endif
    end
    v32 = 0; l32 = 0; sr32 = 0; cr32 = 0; d32 = 0; k32 = 0;
`ifdef CRC_STREAM_CHECK_EN
    exp32 = 32'h0;
`endif
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();

    chk("reset_crc_o", crc8[0], 16'h0);
    chk("reset_valid", cv8[0], 1'b0);
    chk("reset_ready", rdy8[0], 1'b1);
    chk("reset_crc32_o", crc32, 32'h0);
    chk("reset_ready32", rdy32, 1'b1);

    // MAXIM "123456789", result one cycle after last beat, held until acked
    for (int i = 0; i < 8; i++) send8(0, msg[i], 1'b0);
    chk("maxim_no_early_valid", cv8[0], 1'b0);
    send8(0, msg[8], 1'b1);
    chk("maxim_valid_latency", cv8[0], 1'b1);
    chk("maxim_crc", crc8[0], 16'h44C2);
    chk("maxim_hold_ready", rdy8[0], 1'b0);
    tick(); tick();
    chk("maxim_valid_held", cv8[0], 1'b1);
    chk("maxim_crc_held", crc8[0], 16'h44C2);
    ack8(0);
    chk("maxim_ack_valid", cv8[0], 1'b0);
    chk("maxim_ack_ready", rdy8[0], 1'b1);
    chk("maxim_crc_retained", crc8[0], 16'h44C2);

    // valid_i gaps mid-frame, then 5 cycles of backpressure with beats presented
    send_msg(0, 2);
    chk("gap_crc", crc8[0], 16'h44C2);
    v8[0] = 1'b1; d8[0] = 8'hFF; l8[0] = 1'b1; k8[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_ready_low", rdy8[0], 1'b0);
      chk("bp_valid_high", cv8[0], 1'b1);
      chk("bp_crc_stable", crc8[0], 16'h44C2);
    end
    v8[0] = 1'b0; l8[0] = 1'b0;
    ack8(0);
    chk("bp_release_ready", rdy8[0], 1'b1);
    chk("bp_release_valid", cv8[0], 1'b0);

    // soft reset after 4 bytes; beat presented in same cycle is dropped
    for (int i = 0; i < 4; i++) send8(0, msg[i], 1'b0);
    sr8[0] = 1'b1; v8[0] = 1'b1; d8[0] = 8'h35; l8[0] = 1'b1;
    tick();
    sr8[0] = 1'b0; v8[0] = 1'b0; l8[0] = 1'b0;
    chk("srst_valid", cv8[0], 1'b0);
    chk("srst_ready", rdy8[0], 1'b1);
    tick();
    chk("srst_no_result", cv8[0], 1'b0);
    d8[0] = 8'h00;
`ifdef CRC_STREAM_CHECK_EN
    exp8[0] = 16'h44C2;
`endif
    send_msg(0, 0);
    chk("srst_then_crc", crc8[0], 16'h44C2);
    chk("srst_then_valid", cv8[0], 1'b1);
`ifdef CRC_STREAM_CHECK_EN
    chk("check_ok_match", ok8[0], 1'b1);
`endif
    ack8(0);
`ifdef CRC_STREAM_CHECK_EN
    exp8[0] = 16'h44C3;
    send_msg(0, 0);
    chk("check_ok_mismatch", ok8[0], 1'b0);
    chk("check_crc", crc8[0], 16'h44C2);
    ack8(0);
`endif

    // async reset mid-frame discards the partial frame and clears crc_o
    for (int i = 0; i < 4; i++) send8(0, msg[i], 1'b0);
    rst = 1'b1;
    #2;
    chk("arst_crc_o", crc8[0], 16'h0);
    chk("arst_valid", cv8[0], 1'b0);
    tick();
    rst = 1'b0;
    tick();
    send_msg(0, 0);
    chk("arst_then_crc", crc8[0], 16'h44C2);
    ack8(0);

    // CCITT-FALSE twice, second frame with crc_ready_i held high throughout
    send_msg(1, 0);
    chk("ccitt_crc", crc8[1], 16'h29B1);
    chk("ccitt_valid", cv8[1], 1'b1);
    cr8[1] = 1'b1;
    tick();
    send8(1, msg[0], 1'b0);
    chk("ccitt_idle_ack_ignored", cv8[1], 1'b0);
    for (int i = 1; i < 9; i++) send8(1, msg[i], i == 8);
    chk("ccitt_again_crc", crc8[1], 16'h29B1);
    chk("ccitt_again_valid", cv8[1], 1'b1);
    tick();
    cr8[1] = 1'b0;
    chk("ccitt_again_consumed", cv8[1], 1'b0);

    // CRC-32, keep ignored on non-last beats, upper bytes masked on last
    send32(32'h34333231, 4'b0000, 1'b0);
    send32(32'h38373635, 4'b0000, 1'b0);
    send32(32'hAABBCC39, 4'b0001, 1'b1);
    chk("crc32_valid", cv32, 1'b1);
    chk("crc32_crc", crc32, 32'hCBF43926);
    cr32 = 1'b1; tick(); cr32 = 1'b0;
    send32(32'hDEADBEEF, 4'b0000, 1'b1);
    chk("crc32_empty_valid", cv32, 1'b1);
    chk("crc32_empty_crc", crc32, 32'h00000000);
    cr32 = 1'b1; tick(); cr32 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crc_stream.md
Name: crc_stream

Overview:
Framed, streaming CRC generator/checker. Successor to the single-byte-per-cycle CRC calculator, adding:
- multi-byte beats with a byte-enable on the last beat;
- per-frame auto-restart;
- a valid/ready handshake on both input and result.

Sits between a packet source (MAC/UART framer) and the consumer of per-frame CRC results.

Parameters:
POLY, 64'h8005, generator polynomial (low CRC_SIZE bits used, implicit top bit)
CRC_SIZE, 16, CRC width in bits, 8..64
DATA_WIDTH, 8, beat width in bits; multiple of 8, 8..64
INIT, 64'h0000, register value at frame start (low CRC_SIZE bits)
REF_IN, "TRUE", "TRUE" = bit-reverse each input byte before processing
REF_OUT, "TRUE", "TRUE" = bit-reverse final register before XOR_OUT
XOR_OUT, 64'hFFFF, value XORed onto final result (low CRC_SIZE bits)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
soft_reset_i  in  1  synchronous abort: drop frame and result, return to IDLE
valid_i  in  1  input beat valid
ready_o  out  1  block can accept a beat
data_i  in  DATA_WIDTH  beat data; byte 0 = data_i[7:0], processed first
keep_i  in  DATA_WIDTH/8  byte enables; honoured only on last beat
last_i  in  1  beat is final beat of frame
crc_o  out  CRC_SIZE  frame CRC (after REF_OUT and XOR_OUT)
crc_valid_o  out  1  crc_o holds a valid, unconsumed result
crc_ready_i  in  1  consumer accepts result

Behaviour:
- Reset (rst_i high, async): state IDLE, internal register = INIT, crc_o = 0, crc_valid_o = 0, ready_o = 1 (after reset deassert).
- Beat accepted when valid_i & ready_o at posedge clk_i.
- States:
  - IDLE: no frame open; ready_o = 1. Accepted beat with last_i = 0 goes to BUSY; with last_i = 1 goes to HOLD.
  - BUSY: mid-frame; ready_o = 1. Accepted beat with last_i = 1 goes to HOLD.
  - HOLD: ready_o = 0, crc_valid_o = 1. crc_valid_o & crc_ready_i goes to IDLE next cycle.
- Register update is combinational unrolled DATA_WIDTH-bit step, one beat per cycle, no throughput bubbles except HOLD.
- Non-last beats: all DATA_WIDTH/8 bytes processed; keep_i ignored.
- Last beat:
  - Only the contiguous low bytes with keep_i = 1 are processed; keep_i must be of form 0..01..1.
  - keep_i = 0 on last beat: no data processed, frame still closes.
- Latency: crc_o / crc_valid_o valid the cycle after the last beat is accepted.
- crc_o is stable throughout HOLD and retains its value after handshake until the next frame closes.
- Register reloads INIT when entering IDLE, so every frame starts from INIT; no inter-frame gap required beyond HOLD handshake.
- crc_ready_i while crc_valid_o = 0 is ignored.
- soft_reset_i has priority over all else:
  - next cycle: IDLE, register = INIT, crc_valid_o = 0; crc_o unchanged;
  - a beat presented in the same cycle is discarded.
- rst_i mid-frame: partial frame discarded, no result produced.
- valid_i low mid-frame: register holds, state unchanged.

Optional Feature:
Macro CRC_STREAM_CHECK_EN.
- Defined: adds ports crc_exp_i (in, CRC_SIZE) and crc_ok_o (out, 1).
  - crc_exp_i is sampled with the last beat.
  - crc_ok_o = (final CRC == crc_exp_i), registered alongside crc_o, valid while crc_valid_o.
  - crc_ok_o resets to 0 and clears on soft_reset_i.
- Undefined: ports absent, no compare logic.

Test Plan:
- Defaults (CRC-16/MAXIM), "123456789" as 9 single-byte beats, last on 0x39 -> crc_valid_o one cycle later, crc_o = 16'h44C2; stays until crc_ready_i.
- DATA_WIDTH=32, POLY=32'h04C11DB7, CRC_SIZE=32, INIT=XOR_OUT=32'hFFFFFFFF:
  - beats 32'h34333231, 32'h38373635, then 32'h00000039 with keep 4'b0001, last -> crc_o = 32'hCBF43926.
- POLY=16'h1021, INIT=16'hFFFF, REF_IN/REF_OUT="FALSE", XOR_OUT=0, "123456789":
  - -> crc_o = 16'h29B1;
  - same frame sent again back-to-back -> identical 16'h29B1 (INIT reload verified).
- Backpressure: hold crc_ready_i low 5 cycles after result:
  - ready_o = 0 and input beats ignored throughout;
  - crc_ready_i pulse -> IDLE, ready_o = 1 next cycle.
- Soft reset after 4 bytes of "123456789", then full "123456789" frame -> crc_o = 16'h44C2, no result from the aborted frame.
- With CRC_STREAM_CHECK_EN:
  - crc_exp_i = 16'h44C2 -> crc_ok_o = 1;
  - crc_exp_i = 16'h44C3 -> crc_ok_o = 0.
